// File: rtl/demux_arbiter_pkg.sv
// Shared types and constants for the demux_arbiter block.
package demux_arbiter_pkg;

    localparam int NCH   = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

endpackage

// File: rtl/demux_arbiter_rr_pick.sv
// Rotating priority encoder: first set request at or above ptr_i, wrapping 7->0.
module rr_pick
    import demux_arbiter_pkg::*;
(
    input  logic [7:0]       req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic [SEL_W-1:0] winner_o,
    output logic             valid_o
);

    logic [SEL_W-1:0] idx;

    // The 3-bit add wraps naturally, so the search order is ptr, ptr+1, ... ptr-1.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        idx      = '0;
        for (int k = 0; k < 8; k++) begin
            idx = ptr_i + SEL_W'(k);
            if (!valid_o && req_i[idx]) begin
                winner_o = idx;
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_arbiter.sv
// Burst-limited round-robin arbiter steering one serial input to the granted channel.
// Optional macro CH0_PRIO_EN: channel 0 always wins arbitration and never moves the pointer.
module demux_arbiter #(
    parameter int BURST = 4,
    parameter int NCH   = 8
) (
    input  logic           CLK,
    input  logic           RSTN,
    input  logic           I,
    input  logic [NCH-1:0] REQ,
    output logic [2:0]     S,
    output logic [NCH-1:0] O,
    output logic [NCH-1:0] GNT,
    output logic           BUSY
);
    import demux_arbiter_pkg::*;

    localparam logic [7:0]     CNT_INIT = 8'(BURST - 1);
    localparam logic [NCH-1:0] ONE      = 1;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] s_q, s_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [NCH-1:0]   gnt_q, gnt_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             busy_q, busy_d;

    logic [SEL_W-1:0] rr_idx;
    logic             rr_valid;
    logic [SEL_W-1:0] pick_idx;

    rr_pick u_rr_pick (
        .req_i    (REQ),
        .ptr_i    (ptr_q),
        .winner_o (rr_idx),
        .valid_o  (rr_valid)
    );

`ifdef CH0_PRIO_EN
    assign pick_idx = REQ[0] ? '0 : rr_idx;
`else
    assign pick_idx = rr_idx;
`endif

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            s_q     <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // GAP is the single dead cycle; its exit edge is already an arbitration edge.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE, GAP: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
                if (rr_valid) begin
                    state_d = GRANT;
                    s_d     = pick_idx;
                    gnt_d   = ONE << pick_idx;
                    busy_d  = 1'b1;
                    cnt_d   = CNT_INIT;
                end
            end
            GRANT: begin
                if (cnt_q == 8'd0 || !REQ[s_q]) begin
                    state_d = GAP;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = s_q + 1'b1;
`ifdef CH0_PRIO_EN
                    if (s_q == '0) begin
                        ptr_d = ptr_q;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Data path is purely combinational from I, gated by the registered grant.
    assign O    = busy_q ? (gnt_q & {NCH{I}}) : '0;
    assign S    = s_q;
    assign GNT  = gnt_q;
    assign BUSY = busy_q;

endmodule

// File: doc/demux_arbiter.md
DEMUX_ARBITER -- requirements
Module: demux_arbiter

Interface
REQ-001 The block SHALL have parameter BURST, default 4, giving the maximum grant length in clock cycles (legal range 1..255).
REQ-002 The block SHALL have parameter NCH, default 8, giving the channel count (fixed at 8 in this revision).
REQ-003 Port CLK SHALL be an input, 1 bit: the single clock, rising-edge active.
REQ-004 Port RSTN SHALL be an input, 1 bit: the reset, asynchronous and active-low.
REQ-005 Port I SHALL be an input, 1 bit: the shared serial data input to be distributed.
REQ-006 Port REQ SHALL be an input, 8 bits: per-channel request, level-sensitive, one bit per output channel.
REQ-007 Port S SHALL be an output, 3 bits: the registered select of the currently granted channel.
REQ-008 Port O SHALL be an output, 8 bits: the demultiplexed data, with O[S] = I while a grant is active and all other bits 0.
REQ-009 Port GNT SHALL be an output, 8 bits: the registered one-hot grant, all zero when no grant is active.
REQ-010 Port BUSY SHALL be an output, 1 bit: high exactly while a grant is active.

Function
REQ-011 The FSM SHALL have three states: IDLE, GRANT and GAP.
REQ-012 In IDLE with REQ nonzero, the block SHALL select the first set REQ bit searching upward from PTR, with wrap 7->0.
REQ-013 On that arbitration edge the block SHALL load S=winner, GNT=one-hot(winner), BUSY=1 and CNT=BURST-1, then enter GRANT; latency from REQ sampled to GNT visible SHALL be one cycle.
REQ-014 In IDLE with REQ zero, the block SHALL hold S at its last value with GNT=0, BUSY=0 and O=0.
REQ-015 In GRANT, O SHALL be combinational (O[S]=I gated by BUSY), with no register stage on the data path.
REQ-016 In GRANT, CNT SHALL decrement each cycle, and the block SHALL leave for GAP on the edge where CNT==0 or REQ[S]==0, whichever comes first; if both are true on the same edge, the result SHALL be the same single transition.
REQ-017 On leaving GRANT, the block SHALL load PTR=(S+1) mod 8 (7 wraps to 0), and GNT, BUSY and O SHALL be 0 from that edge.
REQ-018 GAP SHALL last exactly one cycle with no grant (break-before-make), then return to IDLE, and arbitration SHALL resume on the following edge.
REQ-019 With BURST=1, each grant SHALL last exactly one cycle.
REQ-020 REQ bits that change during GRANT, other than REQ[S], SHALL NOT affect the current grant.
REQ-021 At most one GNT bit SHALL ever be high, and at most one O bit SHALL be nonzero.

Reset
REQ-022 While RSTN=0 the block SHALL force, immediately and without a clock: state=IDLE, S=000, GNT=00h, O=00h, BUSY=0, PTR=0, CNT=0.
REQ-023 RSTN asserted mid-grant SHALL drop GNT and O asynchronously, and the block SHALL resume arbitrating from PTR=0 on the first clock edge after release.

Configuration
REQ-024 With macro CH0_PRIO_EN defined, REQ[0] SHALL win every IDLE arbitration regardless of PTR, and a channel-0 grant SHALL NOT update PTR.
REQ-025 With CH0_PRIO_EN undefined, the block SHALL use pure round-robin per REQ-012 and REQ-017 for all channels.

Structure
REQ-026 Shared package demux_arbiter_pkg SHALL hold the state enum (IDLE, GRANT, GAP), NCH=8 and SEL_W=3.
REQ-027 The rotating priority encoder (inputs REQ and PTR; outputs winner index and valid) SHALL be a sub-module named rr_pick.

Verification
REQ-028 Reset check: RSTN=0 with REQ=FFh -> S=000, GNT=00h, O=00h and BUSY=0, all without a clock edge.
REQ-029 Single requester: BURST=4, REQ=08h held -> GNT=08h and S=011 one cycle later, held 4 cycles with O[3] following I (1,0,1,0) and other O bits 0, then 1 GAP cycle, then re-grant of channel 3.
REQ-030 All requesting: REQ=FFh held -> grant order 0,1,2,...,7,0, each grant 4 cycles with a 1-cycle gap between grants.
REQ-031 Early release: REQ[2] dropped in the 2nd cycle of its grant -> GNT=00h on the next edge, GAP, then the next requester from PTR=3 is granted.
REQ-032 Reset mid-grant: RSTN pulled low during grant of channel 5 -> GNT and O go to 00h immediately; after release the first grant is the lowest requester at or above 0.
REQ-033 Priority macro: REQ=81h held -> with CH0_PRIO_EN grants are 0,0,0,...; without it grants are 0,7,0,7,....
